// File: rtl/Falco_pkg.sv
// Shared types and widths for the load violation queue.
//   XLEN        : address width
//   ROB_TAG_W   : reorder-buffer tag width (tags wrap modulo 2^ROB_TAG_W)
//   SSIT_WIDTH  : store-set identifier table index width
//   LFST_WIDTH  : last-fetched-store table id width
//   lvq_entry_t : one tracked in-flight load
package Falco_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ROB_TAG_W  = 6;
  localparam int unsigned SSIT_WIDTH = 10;
  localparam int unsigned LFST_WIDTH = 7;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [3:0]           byte_mask_t;

  typedef struct packed {
    logic                  valid;
    logic                  reported;
    logic [XLEN-1:0]       addr;
    byte_mask_t            mask;
    rob_tag_t              tag;
    logic [SSIT_WIDTH-1:0] ssit_pc;
    logic [LFST_WIDTH-1:0] lfst_id;
  } lvq_entry_t;

  // Distance from the ROB head; wraps naturally in ROB_TAG_W bits, so a
  // smaller result is always the older instruction.
  function automatic rob_tag_t rob_age(input rob_tag_t tag, input rob_tag_t head);
    return tag - head;
  endfunction

endpackage

// File: rtl/lvq_oldest_select.sv
// Age-based priority selector.
//   cand_valid_i : one request bit per candidate, NUM_GRP groups of GRP_SIZE
//   cand_age_i   : AGE_W-bit age per candidate (smaller = older)
//   sel_valid_o  : at least one candidate requested
//   sel_grp_o    : group index of the oldest requesting candidate; ties go
//                  to the lowest candidate index, hence the lowest group.
module lvq_oldest_select #(
  parameter int unsigned NUM_GRP  = 16,
  parameter int unsigned GRP_SIZE = 2,
  parameter int unsigned AGE_W    = 6
) (
  input  logic [NUM_GRP*GRP_SIZE-1:0]       cand_valid_i,
  input  logic [NUM_GRP*GRP_SIZE*AGE_W-1:0] cand_age_i,
  output logic                              sel_valid_o,
  output logic [$clog2(NUM_GRP)-1:0]        sel_grp_o
);

  localparam int unsigned GW = $clog2(NUM_GRP);

  logic             found;
  logic [AGE_W-1:0] best_age;
  logic [GW-1:0]    best_grp;

  always_comb begin
    found    = 1'b0;
    best_age = '0;
    best_grp = '0;
    // Strict less-than keeps the first (lowest-index) candidate on a tie.
    for (int g = 0; g < int'(NUM_GRP); g++) begin
      for (int k = 0; k < int'(GRP_SIZE); k++) begin
        if (cand_valid_i[g*GRP_SIZE+k] &&
            (!found || (cand_age_i[(g*GRP_SIZE+k)*AGE_W +: AGE_W] < best_age))) begin
          found    = 1'b1;
          best_age = cand_age_i[(g*GRP_SIZE+k)*AGE_W +: AGE_W];
          best_grp = GW'(g);
        end
      end
    end
  end

  assign sel_valid_o = found;
  assign sel_grp_o   = best_grp;

endmodule

// File: rtl/load_violation_queue.sv
// Load violation queue: tracks in-flight loads and reports the oldest load
// that executed before an older, overlapping store.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   flush_i                  : drop every entry
//   alloc_*                  : allocate handshake and load payload
//   commit_valid_i/_rob_tag_i: retire (free) the load with that tag
//   rob_head_i               : oldest in-flight tag, reference for ages
//   st_*                     : NUM_ST store-check ports
//   viol_*                   : registered violation report
//   count_o                  : number of occupied entries
module load_violation_queue
  import Falco_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NUM_ST = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         alloc_valid_i,
  output logic                         alloc_ready_o,
  input  logic [XLEN-1:0]              alloc_addr_i,
  input  logic [3:0]                   alloc_mask_i,
  input  logic [ROB_TAG_W-1:0]         alloc_rob_tag_i,
  input  logic [SSIT_WIDTH-1:0]        alloc_ssit_pc_i,
  input  logic [LFST_WIDTH-1:0]        alloc_lfst_id_i,
  input  logic                         commit_valid_i,
  input  logic [ROB_TAG_W-1:0]         commit_rob_tag_i,
  input  logic [ROB_TAG_W-1:0]         rob_head_i,
  input  logic [NUM_ST-1:0]            st_valid_i,
  input  logic [NUM_ST*XLEN-1:0]       st_addr_i,
  input  logic [NUM_ST*4-1:0]          st_mask_i,
  input  logic [NUM_ST*ROB_TAG_W-1:0]  st_rob_tag_i,
  output logic                         viol_valid_o,
  output logic [ROB_TAG_W-1:0]         viol_rob_tag_o,
  output logic [SSIT_WIDTH-1:0]        viol_ssit_pc_o,
  output logic [LFST_WIDTH-1:0]        viol_lfst_id_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned NC = DEPTH * NUM_ST;
  // Byte-offset bits are ignored: matching is at word granularity.
  localparam logic [XLEN-1:0] WORD_OFS = XLEN'(3);

  lvq_entry_t            entries_q [DEPTH];
  lvq_entry_t            entries_d [DEPTH];
  logic                  viol_valid_q, viol_valid_d;
  rob_tag_t              viol_tag_q, viol_tag_d;
  logic [SSIT_WIDTH-1:0] viol_ssit_q, viol_ssit_d;
  logic [LFST_WIDTH-1:0] viol_lfst_q, viol_lfst_d;

  logic [CW-1:0]         count;
  logic [IW-1:0]         free_idx;
  logic [DEPTH-1:0]      freeing;
  rob_tag_t              load_age [DEPTH];
  rob_tag_t              st_age   [NUM_ST];
  logic [NC-1:0]         cand_valid;
  logic [NC*ROB_TAG_W-1:0] cand_age;
  logic                  sel_valid;
  logic [IW-1:0]         sel_idx;

  always_comb begin
    count = '0;
    for (int i = 0; i < int'(DEPTH); i++) count = count + CW'(entries_q[i].valid);
  end

  // Lowest-index free slot, taken from the registered state so a slot
  // freed this cycle only becomes reusable next cycle.
  always_comb begin
    free_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) free_idx = IW'(i);
    end
  end

  genvar gi, gj;
  generate
    for (gj = 0; gj < NUM_ST; gj++) begin : g_st_age
      assign st_age[gj] = rob_age(st_rob_tag_i[gj*ROB_TAG_W +: ROB_TAG_W], rob_head_i);
    end
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign freeing[gi]  = commit_valid_i && entries_q[gi].valid &&
                            (entries_q[gi].tag == commit_rob_tag_i);
      assign load_age[gi] = rob_age(entries_q[gi].tag, rob_head_i);
      for (gj = 0; gj < NUM_ST; gj++) begin : g_port
        // An entry being allocated is still invalid here, so it is excluded
        // implicitly; an entry being freed is excluded explicitly.
        assign cand_valid[gi*NUM_ST+gj] =
            entries_q[gi].valid && !entries_q[gi].reported && !freeing[gi] &&
            st_valid_i[gj] &&
            (((entries_q[gi].addr ^ st_addr_i[gj*XLEN +: XLEN]) & ~WORD_OFS) == '0) &&
            ((entries_q[gi].mask & st_mask_i[gj*4 +: 4]) != 4'b0) &&
            (load_age[gi] > st_age[gj]);
        assign cand_age[(gi*NUM_ST+gj)*ROB_TAG_W +: ROB_TAG_W] = load_age[gi];
      end
    end
  endgenerate

  lvq_oldest_select #(
    .NUM_GRP  (DEPTH),
    .GRP_SIZE (NUM_ST),
    .AGE_W    (ROB_TAG_W)
  ) u_select (
    .cand_valid_i (cand_valid),
    .cand_age_i   (cand_age),
    .sel_valid_o  (sel_valid),
    .sel_grp_o    (sel_idx)
  );

  always_comb begin
    entries_d    = entries_q;
    viol_valid_d = 1'b0;
    viol_tag_d   = '0;
    viol_ssit_d  = '0;
    viol_lfst_d  = '0;
    if (flush_i) begin
      for (int i = 0; i < int'(DEPTH); i++) entries_d[i] = '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (freeing[i]) begin
          entries_d[i].valid    = 1'b0;
          entries_d[i].reported = 1'b0;
        end
      end
      if (sel_valid) begin
        entries_d[sel_idx].reported = 1'b1;
        viol_valid_d = 1'b1;
        viol_tag_d   = entries_q[sel_idx].tag;
        viol_ssit_d  = entries_q[sel_idx].ssit_pc;
        viol_lfst_d  = entries_q[sel_idx].lfst_id;
      end
      if (alloc_valid_i && alloc_ready_o) begin
        entries_d[free_idx] = '{valid:    1'b1,
                                reported: 1'b0,
                                addr:     alloc_addr_i,
                                mask:     alloc_mask_i,
                                tag:      alloc_rob_tag_i,
                                ssit_pc:  alloc_ssit_pc_i,
                                lfst_id:  alloc_lfst_id_i};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= '0;
      viol_valid_q <= 1'b0;
      viol_tag_q   <= '0;
      viol_ssit_q  <= '0;
      viol_lfst_q  <= '0;
    end else begin
      entries_q    <= entries_d;
      viol_valid_q <= viol_valid_d;
      viol_tag_q   <= viol_tag_d;
      viol_ssit_q  <= viol_ssit_d;
      viol_lfst_q  <= viol_lfst_d;
    end
  end

  assign alloc_ready_o  = (count < CW'(DEPTH));
  assign count_o        = count;
  assign viol_valid_o   = viol_valid_q;
  assign viol_rob_tag_o = viol_tag_q;
  assign viol_ssit_pc_o = viol_ssit_q;
  assign viol_lfst_id_o = viol_lfst_q;

endmodule

// File: tb/tb_load_violation_queue.sv
// Self-checking bench for load_violation_queue: directed scenarios followed
// by randomized traffic, all checked against a behavioural queue model.
module tb_load_violation_queue;
  import Falco_pkg::*;

  localparam int DEPTH  = 16;
  localparam int NUM_ST = 2;
  localparam int ROBN   = 1 << ROB_TAG_W;
  localparam int CW     = $clog2(DEPTH+1);

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic                        flush_i;
  logic                        alloc_valid_i;
  logic                        alloc_ready_o;
  logic [XLEN-1:0]             alloc_addr_i;
  logic [3:0]                  alloc_mask_i;
  logic [ROB_TAG_W-1:0]        alloc_rob_tag_i;
  logic [SSIT_WIDTH-1:0]       alloc_ssit_pc_i;
  logic [LFST_WIDTH-1:0]       alloc_lfst_id_i;
  logic                        commit_valid_i;
  logic [ROB_TAG_W-1:0]        commit_rob_tag_i;
  logic [ROB_TAG_W-1:0]        rob_head_i;
  logic [NUM_ST-1:0]           st_valid_i;
  logic [NUM_ST*XLEN-1:0]      st_addr_i;
  logic [NUM_ST*4-1:0]         st_mask_i;
  logic [NUM_ST*ROB_TAG_W-1:0] st_rob_tag_i;
  logic                        viol_valid_o;
  logic [ROB_TAG_W-1:0]        viol_rob_tag_o;
  logic [SSIT_WIDTH-1:0]       viol_ssit_pc_o;
  logic [LFST_WIDTH-1:0]       viol_lfst_id_o;
  logic [CW-1:0]               count_o;

  load_violation_queue #(.DEPTH(DEPTH), .NUM_ST(NUM_ST)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_addr_i(alloc_addr_i), .alloc_mask_i(alloc_mask_i),
    .alloc_rob_tag_i(alloc_rob_tag_i), .alloc_ssit_pc_i(alloc_ssit_pc_i),
    .alloc_lfst_id_i(alloc_lfst_id_i),
    .commit_valid_i(commit_valid_i), .commit_rob_tag_i(commit_rob_tag_i),
    .rob_head_i(rob_head_i),
    .st_valid_i(st_valid_i), .st_addr_i(st_addr_i), .st_mask_i(st_mask_i),
    .st_rob_tag_i(st_rob_tag_i),
    .viol_valid_o(viol_valid_o), .viol_rob_tag_o(viol_rob_tag_o),
    .viol_ssit_pc_o(viol_ssit_pc_o), .viol_lfst_id_o(viol_lfst_id_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the queue contents.
  bit m_valid [DEPTH];
  bit m_rep   [DEPTH];
  int m_addr  [DEPTH];
  int m_mask  [DEPTH];
  int m_tag   [DEPTH];
  int m_ssit  [DEPTH];
  int m_lfst  [DEPTH];
  int e_vv, e_tag, e_ssit, e_lfst;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int age(input int t);
    return (t - int'(rob_head_i) + ROBN) % ROBN;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_rep[i] = 0;
    end
    e_vv = 0; e_tag = 0; e_ssit = 0; e_lfst = 0;
  endtask

  task automatic idle();
    flush_i = 0; alloc_valid_i = 0; commit_valid_i = 0; st_valid_i = '0;
  endtask

  task automatic do_alloc(input int tag, input int addr, input int mask, input int ssit, input int lfst);
    alloc_valid_i   = 1;
    alloc_rob_tag_i = ROB_TAG_W'(tag);
    alloc_addr_i    = XLEN'(addr);
    alloc_mask_i    = 4'(mask);
    alloc_ssit_pc_i = SSIT_WIDTH'(ssit);
    alloc_lfst_id_i = LFST_WIDTH'(lfst);
  endtask

  task automatic do_commit(input int tag);
    commit_valid_i   = 1;
    commit_rob_tag_i = ROB_TAG_W'(tag);
  endtask

  task automatic set_store(input int p, input int tag, input int addr, input int mask);
    st_valid_i[p] = 1'b1;
    st_rob_tag_i[p*ROB_TAG_W +: ROB_TAG_W] = ROB_TAG_W'(tag);
    st_addr_i[p*XLEN +: XLEN] = XLEN'(addr);
    st_mask_i[p*4 +: 4] = 4'(mask);
  endtask

  // Predict the effect of the current inputs, clock once, compare.
  task automatic step(input string tag_name);
    int best, best_age, slot, la, sa, sadr;
    bit fr [DEPTH];
    e_vv = 0; e_tag = 0; e_ssit = 0; e_lfst = 0;
    if (flush_i) begin
      model_reset();
    end else begin
      for (int e = 0; e < DEPTH; e++)
        fr[e] = commit_valid_i && m_valid[e] && (m_tag[e] == int'(commit_rob_tag_i));
      best = -1; best_age = 0;
      for (int e = 0; e < DEPTH; e++) begin
        for (int p = 0; p < NUM_ST; p++) begin
          sadr = int'(st_addr_i[p*XLEN +: XLEN]);
          if (m_valid[e] && !m_rep[e] && !fr[e] && st_valid_i[p] &&
              ((m_addr[e] >>> 2) == (sadr >>> 2)) &&
              ((m_mask[e] & int'(st_mask_i[p*4 +: 4])) != 0)) begin
            la = age(m_tag[e]);
            sa = age(int'(st_rob_tag_i[p*ROB_TAG_W +: ROB_TAG_W]));
            if (la > sa && (best < 0 || la < best_age)) begin
              best = e; best_age = la;
            end
          end
        end
      end
      slot = -1;
      if (alloc_valid_i && model_count() < DEPTH) begin
        for (int e = DEPTH - 1; e >= 0; e--) if (!m_valid[e]) slot = e;
      end
      for (int e = 0; e < DEPTH; e++) if (fr[e]) begin m_valid[e] = 0; m_rep[e] = 0; end
      if (best >= 0) begin
        m_rep[best] = 1;
        e_vv = 1; e_tag = m_tag[best]; e_ssit = m_ssit[best]; e_lfst = m_lfst[best];
      end
      if (slot >= 0) begin
        m_valid[slot] = 1; m_rep[slot] = 0;
        m_addr[slot] = int'(alloc_addr_i); m_mask[slot] = int'(alloc_mask_i);
        m_tag[slot] = int'(alloc_rob_tag_i); m_ssit[slot] = int'(alloc_ssit_pc_i);
        m_lfst[slot] = int'(alloc_lfst_id_i);
      end
    end
    @(posedge clk_i); #1;
    chk({tag_name, ".viol_valid"}, 32'(viol_valid_o), 32'(e_vv));
    chk({tag_name, ".viol_tag"},   32'(viol_rob_tag_o), 32'(e_tag));
    chk({tag_name, ".viol_ssit"},  32'(viol_ssit_pc_o), 32'(e_ssit));
    chk({tag_name, ".viol_lfst"},  32'(viol_lfst_id_o), 32'(e_lfst));
    chk({tag_name, ".count"},      32'(count_o), 32'(model_count()));
    chk({tag_name, ".ready"},      32'(alloc_ready_o), 32'(model_count() < DEPTH));
    $display("step %-10s viol=%0d tag=%0d count=%0d ready=%0d", tag_name,
             viol_valid_o, viol_rob_tag_o, count_o, alloc_ready_o);
  endtask

  initial begin
    int t, dup, idx;
    rst_ni = 0; idle(); rob_head_i = '0;
    alloc_addr_i = '0; alloc_mask_i = '0; alloc_rob_tag_i = '0;
    alloc_ssit_pc_i = '0; alloc_lfst_id_i = '0; commit_rob_tag_i = '0;
    st_addr_i = '0; st_mask_i = '0; st_rob_tag_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst.count", 32'(count_o), 0);
    chk("rst.viol_valid", 32'(viol_valid_o), 0);
    chk("rst.viol_tag", 32'(viol_rob_tag_o), 0);
    chk("rst.viol_ssit", 32'(viol_ssit_pc_o), 0);
    chk("rst.viol_lfst", 32'(viol_lfst_id_o), 0);
    rst_ni = 1;
    step("idle");
    chk("rel.ready", 32'(alloc_ready_o), 1);

    // Basic detection and the non-matching cases.
    idle(); do_alloc(5, 'h100, 'hF, 'h11, 'h3); step("alloc5");
    idle(); set_store(0, 7, 'h102, 'h4); step("st_young");
    chk("young.viol", 32'(viol_valid_o), 0);
    idle(); set_store(0, 3, 'h102, 'h0); step("st_mask0");
    chk("mask0.viol", 32'(viol_valid_o), 0);
    idle(); set_store(0, 3, 'h104, 'hF); step("st_addr");
    chk("addr.viol", 32'(viol_valid_o), 0);
    idle(); set_store(0, 3, 'h102, 'h4); step("st_hit");
    chk("hit.viol", 32'(viol_valid_o), 1);
    chk("hit.tag", 32'(viol_rob_tag_o), 5);
    idle(); step("after_hit");
    chk("after_hit.viol", 32'(viol_valid_o), 0);
    idle(); do_commit(5); step("commit5");

    // ROB wrap-around.
    idle(); rob_head_i = 6'd60; do_alloc(2, 'h200, 'h1, 'h22, 'h4); step("alloc2");
    idle(); set_store(0, 62, 'h203, 'h1); step("st_wrap");
    chk("wrap.viol", 32'(viol_valid_o), 1);
    chk("wrap.tag", 32'(viol_rob_tag_o), 2);
    idle(); do_commit(2); step("commit2");

    // Oldest selection across ports; each load reports only once.
    idle(); rob_head_i = '0; do_alloc(9, 'h300, 'hF, 'h33, 'h9); step("alloc9");
    idle(); do_alloc(6, 'h300, 'hF, 'h36, 'h6); step("alloc6");
    idle(); set_store(0, 4, 'h300, 'h1); set_store(1, 5, 'h301, 'h2); step("st_two");
    chk("two.viol", 32'(viol_valid_o), 1);
    chk("two.tag", 32'(viol_rob_tag_o), 6);
    idle(); step("two_idle");
    chk("two_idle.viol", 32'(viol_valid_o), 0);
    idle(); set_store(0, 4, 'h300, 'h1); step("st_again");
    chk("again.tag", 32'(viol_rob_tag_o), 9);
    idle(); set_store(0, 4, 'h300, 'h1); step("st_third");
    chk("third.viol", 32'(viol_valid_o), 0);
    idle(); do_commit(9); step("commit9");
    idle(); do_commit(6); step("commit6");

    // Fill, full allocate+commit, flush.
    for (int i = 0; i < DEPTH; i++) begin
      idle(); do_alloc(10 + i, 'h1000 + i * 16, 'hF, i, i); step("fill");
    end
    chk("full.ready", 32'(alloc_ready_o), 0);
    chk("full.count", 32'(count_o), DEPTH);
    idle(); do_alloc(40, 'h2000, 'hF, 0, 0); do_commit(10); step("full_ac");
    chk("full_ac.count", 32'(count_o), DEPTH - 1);
    chk("full_ac.ready", 32'(alloc_ready_o), 1);
    idle(); flush_i = 1; set_store(0, 0, 'h1010, 'hF); step("flush");
    chk("flush.count", 32'(count_o), 0);

    // Asynchronous reset between a match and its output edge.
    idle(); do_alloc(5, 'h100, 'hF, 1, 1); step("alloc5b");
    idle(); set_store(0, 3, 'h102, 'h4);
    #2 rst_ni = 0;
    #1;
    chk("arst.count_now", 32'(count_o), 0);
    model_reset();
    @(posedge clk_i); #1;
    chk("arst.viol", 32'(viol_valid_o), 0);
    chk("arst.count", 32'(count_o), 0);
    idle(); rst_ni = 1;
    step("arst_rel");

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      idle();
      rob_head_i = ROB_TAG_W'($urandom_range(0, ROBN - 1));
      if ($urandom_range(0, 99) < 60) begin
        t = $urandom_range(0, ROBN - 1);
        dup = 0;
        for (int e = 0; e < DEPTH; e++) if (m_valid[e] && m_tag[e] == t) dup = 1;
        if (!dup)
          do_alloc(t, 'h400 + 4 * $urandom_range(0, 1) + $urandom_range(0, 3),
                   $urandom_range(0, 15), $urandom_range(0, 1023), $urandom_range(0, 127));
      end
      if ($urandom_range(0, 99) < 35) begin
        idx = $urandom_range(0, DEPTH - 1);
        do_commit(m_valid[idx] ? m_tag[idx] : $urandom_range(0, ROBN - 1));
      end
      for (int p = 0; p < NUM_ST; p++) begin
        if ($urandom_range(0, 1) == 1)
          set_store(p, $urandom_range(0, ROBN - 1),
                    'h400 + 4 * $urandom_range(0, 1) + $urandom_range(0, 3),
                    $urandom_range(0, 15));
      end
      if ($urandom_range(0, 99) < 2) flush_i = 1;
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_violation_queue.md
LOAD_VIOLATION_QUEUE -- requirements
Module: load_violation_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, which is the number of load entries; it is a power of two, 4..64.
REQ-002 The block SHALL have parameter NUM_ST, default 2, which is the number of store-check ports per cycle, 1..4.
REQ-003 The block SHALL use one clock and one reset: clk_i  in  1  rising-edge clock; rst_ni  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have flush_i  in  1  which invalidates all entries.
REQ-005 The block SHALL have the allocate ports alloc_valid_i  in  1 and alloc_ready_o  out  1, forming the allocate handshake.
REQ-006 The block SHALL have alloc_addr_i  in  XLEN (load address), alloc_mask_i  in  4 (byte mask) and alloc_rob_tag_i  in  ROB_TAG_W.
REQ-007 The block SHALL have alloc_ssit_pc_i  in  SSIT_WIDTH and alloc_lfst_id_i  in  LFST_WIDTH, carrying the store-set index and the store-set id.
REQ-008 The block SHALL have commit_valid_i  in  1 and commit_rob_tag_i  in  ROB_TAG_W, which free the entry of a retiring load.
REQ-009 The block SHALL have rob_head_i  in  ROB_TAG_W, the tag of the oldest in-flight instruction, used for age computation.
REQ-010 The block SHALL have st_valid_i  in  NUM_ST, st_addr_i  in  NUM_ST*XLEN, st_mask_i  in  NUM_ST*4 and st_rob_tag_i  in  NUM_ST*ROB_TAG_W.
REQ-011 The block SHALL have viol_valid_o  out  1, viol_rob_tag_o  out  ROB_TAG_W, viol_ssit_pc_o  out  SSIT_WIDTH and viol_lfst_id_o  out  LFST_WIDTH.
REQ-012 The block SHALL have count_o  out  $clog2(DEPTH+1), the number of occupied entries.

Function
REQ-013 alloc_ready_o SHALL be 1 iff count_o < DEPTH; an allocate SHALL occur on a cycle where alloc_valid_i && alloc_ready_o.
REQ-014 An allocate SHALL write the lowest-index free entry and set valid=1, reported=0.
REQ-015 A slot freed in a cycle SHALL NOT be reused in that same cycle.
REQ-016 On commit_valid_i, the valid entry whose tag equals commit_rob_tag_i SHALL be cleared; a commit with no matching entry SHALL have no effect.
REQ-017 Age SHALL be computed as (tag - rob_head_i) modulo 2^ROB_TAG_W, unsigned, so that ROB wrap-around orders correctly; a smaller age is older.
REQ-018 A store port p and entry e SHALL match when all of the following hold: e is valid; e is not reported; e is not being allocated or freed this cycle; st_valid_i[p]; addr[XLEN-1:2] is equal; (mask_e & st_mask_p) != 0; and age(e) > age(store p).
REQ-019 When one or more matches exist in a cycle, the block SHALL select the single oldest matching load across all ports; ties SHALL go to the lowest index.
REQ-020 The selected entry SHALL have reported set to 1 at the next edge, so that it never reports twice.
REQ-021 viol_* SHALL be registered with a one-cycle latency: a match in cycle N yields viol_valid_o=1 with that entry's tag, ssit_pc and lfst_id in cycle N+1, and 0 otherwise.
REQ-022 A load allocated in cycle N SHALL be checked against stores from cycle N+1 onward.
REQ-023 flush_i SHALL clear all valid and reported bits, suppress viol_valid_o the next cycle, and take priority over allocate, commit and detect in the same cycle.
REQ-024 count_o SHALL equal the popcount of valid bits, and SHALL be updated in the same edge as allocate, commit and flush.
REQ-025 A simultaneous allocate and commit while full SHALL NOT allocate, because alloc_ready_o is low.

Reset
REQ-026 While rst_ni=0, all valid and reported bits SHALL be 0, count_o=0, viol_valid_o=0 and viol_* payloads=0, with alloc_ready_o=1 after release.
REQ-027 A reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-028 The package (Falco_pkg) SHALL hold XLEN, ROB_TAG_W, SSIT_WIDTH, LFST_WIDTH, rob_tag_t, byte_mask_t and a new packed lvq_entry_t of {valid, reported, addr, mask, tag, ssit_pc, lfst_id}.
REQ-029 The design SHALL include one sub-module, lvq_oldest_select, a parametrised age-based priority selector over DEPTH*NUM_ST candidates.

Verification
REQ-030 With rob_head=0, allocate load tag 5, addr 0x100, mask 0xF, then present store port0 tag 3, addr 0x102, mask 0x4 -> viol_valid_o=1 one cycle later with tag 5.
REQ-031 Same load with store tag 7 -> no violation; with store mask 0x0 or addr 0x104 -> no violation.
REQ-032 rob_head=60 with ROB_TAG_W=6: load tag 2 and store tag 62 at the same word -> violation, because load age 6 > store age 2.
REQ-033 Loads tag 9 and tag 6 both match store port0 tag 4 and store port1 tag 5 in one cycle -> a single report with tag 6, then a report with tag 9 only after a further store match; a repeated store to tag 6 -> no report.
REQ-034 Fill DEPTH entries -> alloc_ready_o=0 and count_o=DEPTH; commit one tag -> alloc_ready_o=1 the next cycle; flush -> count_o=0.
REQ-035 Assert rst_ni low for one cycle after a match and before the output edge -> viol_valid_o=0 and count_o=0.
